// File: rtl/rv32i_sequencer_if.sv
// rv32i_sequencer_if: memory request/completion bus between the sequencer and memory.
// master = sequencer side, slave = memory side.
interface rv32i_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/rv32i_sequencer.sv
// rv32i_sequencer: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional feature: define RV32I_SEQ_TIMEOUT_EN to add an 8-bit memory wait timeout
// that raises bus_err and traps; without it waits are unbounded and bus_err is 0.
module rv32i_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  rv32i_sequencer_if.master    bus,
  input  logic                 branch_taken,
  output logic [31:0]          ir,
  output logic                 rf_we,
  output logic                 pc_en,
  output logic [1:0]           pc_sel,
  output logic [2:0]           state,
  output logic                 illegal,
  output logic                 bus_err,
  output logic                 retire,
  output logic [31:0]          instret
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcBranch = 2'd1;
  localparam logic [1:0] PcJal    = 2'd2;
  localparam logic [1:0] PcJalr   = 2'd3;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;
  logic        mem_req_c, mem_we_c;
  logic [6:0]  opcode;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_legal;

`ifdef RV32I_SEQ_TIMEOUT_EN
  logic [7:0]  wait_q, wait_d;
  logic        bus_err_q, bus_err_d;
`endif

  assign opcode = ir_q[6:0];

  // Classify the latched opcode; ir is stable from DECODE through WB.
  always_comb begin
    is_load   = (opcode == OpcLoad);
    is_store  = (opcode == OpcStore);
    is_branch = (opcode == OpcBranch);
    is_jal    = (opcode == OpcJal);
    is_jalr   = (opcode == OpcJalr);
    is_legal  = is_load | is_store | is_branch | is_jal | is_jalr |
                (opcode == OpcOp) | (opcode == OpcOpImm) |
                (opcode == OpcLui) | (opcode == OpcAuipc);
  end

  // Next-state, strobes and bus request for the current state.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    rf_we     = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = PcPlus4;

    case (state_q)
      StFetch: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_legal) begin
          state_d = StExec;
        end else begin
          illegal_d = 1'b1;
          state_d   = StTrap;
        end
      end
      StExec: begin
        if (is_load || is_store) begin
          state_d = StMem;
        end else if (is_branch) begin
          pc_en   = 1'b1;
          pc_sel  = branch_taken ? PcBranch : PcPlus4;
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_store;
        if (bus.mem_ready) begin
          if (is_store) begin
            pc_en   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we   = (ir_q[11:7] != 5'd0);
        pc_en   = 1'b1;
        pc_sel  = is_jal ? PcJal : (is_jalr ? PcJalr : PcPlus4);
        state_d = StFetch;
      end
      StTrap: state_d = StTrap;
      default: state_d = StTrap;
    endcase

    if (pc_en) begin
      instret_d = instret_q + 32'd1;
    end

`ifdef RV32I_SEQ_TIMEOUT_EN
    // Counter is zero whenever no access is stalled, so it is clear on every FETCH/MEM entry.
    // A completing mem_ready takes priority over the timeout.
    bus_err_d = bus_err_q;
    wait_d    = 8'd0;
    if (mem_req_c && !bus.mem_ready) begin
      if (wait_q == 8'hFF) begin
        bus_err_d = 1'b1;
        state_d   = StTrap;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
`endif
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      ir_q      <= 32'd0;
      instret_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef RV32I_SEQ_TIMEOUT_EN
  // Wait counter and sticky bus error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Reset state is FETCH, so the request is masked by rst_n to stay quiet during reset.
  assign bus.mem_req = mem_req_c & rst_n;
  assign bus.mem_we  = mem_we_c & rst_n;
  assign state       = state_q;
  assign ir          = ir_q;
  assign illegal     = illegal_q;
  assign retire      = pc_en;
  assign instret     = instret_q;

endmodule

// File: tb/tb_rv32i_sequencer.sv
// tb_rv32i_sequencer: scoreboard bench for rv32i_sequencer.
module tb_rv32i_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] ir, instret;
  logic        rf_we, pc_en, illegal, bus_err, retire;
  logic [1:0]  pc_sel;
  logic [2:0]  state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = 32'd0;

  typedef struct {
    logic [1:0]  pc_sel;
    int          rf_we;
    int          cycles;
    logic [31:0] ir;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        taken;
    logic [1:0]  sel;
    int          rf;
    int          base;
    bit          mem;
    logic        we;
  } prog_t;

  exp_t  sb_q[$];
  prog_t prog[8];

  rv32i_sequencer_if bus_if();

  rv32i_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if.master),
    .branch_taken (branch_taken),
    .ir           (ir),
    .rf_we        (rf_we),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .state        (state),
    .illegal      (illegal),
    .bus_err      (bus_err),
    .retire       (retire),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Hold reset for two edges, release just after a rising edge; FSM is then in FETCH.
  task automatic do_reset();
    bus_if.mem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_instret = 32'd0;
    sb_q.delete();
  endtask

  // Run one instruction from FETCH entry to the next FETCH entry.
  task automatic run_instr(input string name, input logic [31:0] instr, input int fwait,
                           input int mwait, input logic taken, input logic [1:0] e_sel,
                           input int e_rf, input int e_cyc, input logic e_we);
    exp_t       e, got;
    int         fcnt = 0;
    int         mcnt = 0;
    int         cyc = 0;
    int         rf_cnt = 0;
    bit         done = 0;
    logic [2:0] st;
    logic       exp_req, exp_we;
    e.pc_sel = e_sel;
    e.rf_we  = e_rf;
    e.cycles = e_cyc;
    e.ir     = instr;
    sb_q.push_back(e);
    exp_instret = exp_instret + 32'd1;
    branch_taken = taken;
    for (int c = 0; c < 64 && !done; c++) begin
      st = state;
      bus_if.mem_rdata = (st == 3'd0) ? instr : 32'hDEAD_BEEF;
      if (st == 3'd0) begin
        bus_if.mem_ready = (fcnt >= fwait);
        fcnt++;
      end else if (st == 3'd3) begin
        bus_if.mem_ready = (mcnt >= mwait);
        mcnt++;
      end else begin
        bus_if.mem_ready = 1'b1;
      end
      exp_req = (st == 3'd0) || (st == 3'd3);
      exp_we  = (st == 3'd3) ? e_we : 1'b0;
      @(negedge clk);
      cyc++;
      checks++;
      if (bus_if.mem_req !== exp_req) begin
        errors++;
        $display("FAIL %s mem_req st=%0d got %b want %b", name, st, bus_if.mem_req, exp_req);
      end
      if (exp_req) begin
        checks++;
        if (bus_if.mem_we !== exp_we) begin
          errors++;
          $display("FAIL %s mem_we st=%0d got %b want %b", name, st, bus_if.mem_we, exp_we);
        end
      end
      checks++;
      if (retire !== pc_en) begin
        errors++;
        $display("FAIL %s retire got %b want %b", name, retire, pc_en);
      end
      if (rf_we === 1'b1) rf_cnt++;
      if (pc_en === 1'b1) begin
        done = 1;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL %s scoreboard got unexpected retire want none", name);
        end else begin
          got = sb_q.pop_front();
          if (pc_sel !== got.pc_sel || rf_cnt != got.rf_we || cyc != got.cycles ||
              ir !== got.ir) begin
            errors++;
            $display("FAIL %s retire got sel=%0d rf=%0d cyc=%0d ir=%h want sel=%0d rf=%0d cyc=%0d ir=%h",
                     name, pc_sel, rf_cnt, cyc, ir, got.pc_sel, got.rf_we, got.cycles, got.ir);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    bus_if.mem_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout got no retire want retire within 64 cycles", name);
    end else if (state !== 3'd0 || instret !== exp_instret) begin
      errors++;
      $display("FAIL %s post got state=%0d instret=%h want state=0 instret=%h",
               name, state, instret, exp_instret);
    end
  endtask

  task automatic test_reset();
    bus_if.mem_ready = 1'b0;
    bus_if.mem_rdata = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, ir, instret, illegal, bus_err, bus_if.mem_req, rf_we, pc_en, retire} !== '0) begin
      errors++;
      $display("FAIL reset_async got state=%0d ir=%h instret=%h ill=%b berr=%b req=%b rf=%b pc=%b ret=%b want all 0",
               state, ir, instret, illegal, bus_err, bus_if.mem_req, rf_we, pc_en, retire);
    end
    @(posedge clk);
    #1;
    checks++;
    if (state !== 3'd0 || bus_if.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_held got state=%0d req=%b want 0 0", state, bus_if.mem_req);
    end
    rst_n = 1'b1;
    exp_instret = 32'd0;
    @(posedge clk);
    #1;
    checks++;
    if (state !== 3'd0 || bus_if.mem_req !== 1'b1 || bus_if.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got state=%0d req=%b we=%b want 0 1 0",
               state, bus_if.mem_req, bus_if.mem_we);
    end
  endtask

  task automatic test_alu();
    run_instr("addi", 32'h0050_0093, 0, 0, 1'b0, 2'd0, 1, 4, 1'b0);
    run_instr("addi_fwait", 32'h0050_0093, 2, 0, 1'b0, 2'd0, 1, 6, 1'b0);
    run_instr("lui", 32'h1234_50B7, 0, 0, 1'b0, 2'd0, 1, 4, 1'b0);
    run_instr("auipc", 32'h0000_0097, 0, 0, 1'b0, 2'd0, 1, 4, 1'b0);
  endtask

  task automatic test_jumps();
    run_instr("jal", 32'h0080_00EF, 0, 0, 1'b0, 2'd2, 1, 4, 1'b0);
    run_instr("jalr", 32'h0000_80E7, 0, 0, 1'b0, 2'd3, 1, 4, 1'b0);
  endtask

  task automatic test_load_store();
    run_instr("lw_wait3", 32'h0000_2083, 0, 3, 1'b0, 2'd0, 1, 8, 1'b0);
    run_instr("lw", 32'h0000_2083, 0, 0, 1'b0, 2'd0, 1, 5, 1'b0);
    run_instr("sw", 32'h0020_A023, 0, 0, 1'b0, 2'd0, 0, 4, 1'b1);
    run_instr("sw_wait2", 32'h0020_A023, 1, 2, 1'b0, 2'd0, 0, 7, 1'b1);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 32'h0000_0063, 0, 0, 1'b1, 2'd1, 0, 3, 1'b0);
    run_instr("beq_not", 32'h0000_0063, 0, 0, 1'b0, 2'd0, 0, 3, 1'b0);
  endtask

  task automatic test_rd_zero();
    run_instr("add_x0", 32'h0000_0033, 0, 0, 1'b0, 2'd0, 0, 4, 1'b0);
  endtask

  task automatic test_back_to_back();
    int fw, mw;
    prog[0] = '{32'h0050_0093, 1'b0, 2'd0, 1, 4, 1'b0, 1'b0};
    prog[1] = '{32'h0020_A023, 1'b0, 2'd0, 0, 4, 1'b1, 1'b1};
    prog[2] = '{32'h0000_2083, 1'b0, 2'd0, 1, 5, 1'b1, 1'b0};
    prog[3] = '{32'h0000_0063, 1'b1, 2'd1, 0, 3, 1'b0, 1'b0};
    prog[4] = '{32'h0080_00EF, 1'b0, 2'd2, 1, 4, 1'b0, 1'b0};
    prog[5] = '{32'h0000_80E7, 1'b0, 2'd3, 1, 4, 1'b0, 1'b0};
    prog[6] = '{32'h1234_50B7, 1'b0, 2'd0, 1, 4, 1'b0, 1'b0};
    prog[7] = '{32'h0000_0063, 1'b0, 2'd0, 0, 3, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      fw = $urandom_range(0, 2);
      mw = prog[i].mem ? $urandom_range(0, 3) : 0;
      run_instr($sformatf("b2b_%0d", i), prog[i].instr, fw, mw, prog[i].taken, prog[i].sel,
                prog[i].rf, prog[i].base + fw + mw, prog[i].we);
    end
  endtask

  task automatic test_instret_wrap();
    bus_if.mem_ready = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.instret_q;
    exp_instret = 32'hFFFF_FFFF;
    checks++;
    if (instret !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL instret_preload got %h want ffffffff", instret);
    end
    run_instr("wrap_add_x0", 32'h0000_0033, 0, 0, 1'b0, 2'd0, 0, 4, 1'b0);
    checks++;
    if (instret !== 32'd0) begin
      errors++;
      $display("FAIL instret_wrap got %h want 00000000", instret);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    bus_if.mem_rdata = 32'hFFFF_FFFF;
    bus_if.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.mem_ready = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL illegal_decode got state=%0d want 1", state);
    end
    @(posedge clk);
    #1;
    checks++;
    if (state !== 3'd5 || illegal !== 1'b1 || bus_if.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL illegal_trap got state=%0d ill=%b req=%b want 5 1 0",
               state, illegal, bus_if.mem_req);
    end
    for (int i = 0; i < 20; i++) begin
      bus_if.mem_ready = 1'($urandom_range(0, 1));
      bus_if.mem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({state, illegal, bus_if.mem_req, rf_we, pc_en, retire} !== {3'd5, 5'b10000} ||
          ir !== 32'hFFFF_FFFF || instret !== exp_instret) begin
        errors++;
        $display("FAIL trap_hold got state=%0d ill=%b req=%b rf=%b pc=%b ir=%h instret=%h want 5 1 0 0 0 ffffffff %h",
                 state, illegal, bus_if.mem_req, rf_we, pc_en, ir, instret, exp_instret);
      end
      @(posedge clk);
      #1;
    end
    bus_if.mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0 || ir !== 32'd0 || bus_if.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL trap_reset got state=%0d ill=%b ir=%h req=%b want 0 0 0 0",
               state, illegal, ir, bus_if.mem_req);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_instret = 32'd0;
  endtask

  task automatic test_reset_mid_access();
    bus_if.mem_rdata = 32'h0000_2083;
    bus_if.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus_if.mem_ready = 1'b0;
    checks++;
    if (state !== 3'd3 || bus_if.mem_req !== 1'b1 || bus_if.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_mem got state=%0d req=%b we=%b want 3 1 0",
               state, bus_if.mem_req, bus_if.mem_we);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || bus_if.mem_req !== 1'b0 || ir !== 32'd0 || instret !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset got state=%0d req=%b ir=%h instret=%h want 0 0 0 0",
               state, bus_if.mem_req, ir, instret);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_instret = 32'd0;
    @(posedge clk);
    #1;
    checks++;
    if (state !== 3'd0 || bus_if.mem_req !== 1'b1 || bus_if.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_fresh got state=%0d req=%b we=%b want 0 1 0",
               state, bus_if.mem_req, bus_if.mem_we);
    end
    run_instr("after_abort", 32'h0050_0093, 0, 0, 1'b0, 2'd0, 1, 4, 1'b0);
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
`ifdef RV32I_SEQ_TIMEOUT_EN
    while (state !== 3'd5 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 256 || bus_err !== 1'b1 || bus_if.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout got cycles=%0d berr=%b req=%b want 256 1 0",
               n, bus_err, bus_if.mem_req);
    end
`else
    repeat (300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (state !== 3'd0 || bus_if.mem_req !== 1'b1 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout after %0d got state=%0d req=%b berr=%b want 0 1 0",
               n, state, bus_if.mem_req, bus_err);
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jumps();
    test_load_store();
    test_branch();
    test_rd_zero();
    test_back_to_back();
    test_instret_wrap();
    test_illegal();
    test_reset_mid_access();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_sequencer.md
RV32I_SEQUENCER -- requirements
Module: rv32i_sequencer

Interface
REQ-001 clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 mem_req  output  1  memory access request (fetch or data).
REQ-004 mem_we  output  1  1 = store access, 0 = read; meaningful only while mem_req=1.
REQ-005 mem_ready  input  1  memory completion; the access completes on a cycle with mem_req=1 and mem_ready=1.
REQ-006 mem_rdata  input  32  read data; captured into ir on completion of a fetch.
REQ-007 branch_taken  input  1  branch compare result from the datapath; sampled in EXEC.
REQ-008 ir  output  32  latched instruction register.
REQ-009 rf_we  output  1  register-file write strobe, one cycle.
REQ-010 pc_en  output  1  PC update strobe, one cycle.
REQ-011 pc_sel  output  2  PC source: 0 = +4, 1 = branch target, 2 = jal target, 3 = jalr target.
REQ-012 state  output  3  current FSM state.
REQ-013 illegal  output  1  sticky illegal-opcode flag.
REQ-014 bus_err  output  1  sticky memory-timeout flag.
REQ-015 retire  output  1  one-cycle pulse per completed instruction; equal to pc_en.
REQ-016 instret  output  32  retired-instruction counter.

Function
REQ-017 State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL go to TRAP on the next edge.
REQ-018 FETCH: mem_req=1 and mem_we=0; on mem_ready, ir <= mem_rdata and the FSM SHALL move to DECODE; otherwise it SHALL stay in FETCH.
REQ-019 DECODE: ir[6:0] is classified as one of LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111 or JALR 1100111.
- Any other opcode SHALL set illegal=1 and move to TRAP.
- Otherwise the FSM SHALL move to EXEC.
REQ-020 EXEC: LOAD and STORE SHALL move to MEM.
- BRANCH SHALL assert pc_en with pc_sel=1 if branch_taken, else pc_sel=0, then move to FETCH.
- All other classes SHALL move to WB.
REQ-021 MEM: mem_req=1 and mem_we=(STORE).
- On mem_ready, LOAD SHALL move to WB.
- On mem_ready, STORE SHALL assert pc_en with pc_sel=0 and move to FETCH.
REQ-022 WB: rf_we=1 unless ir[11:7]==0.
- pc_en=1 with pc_sel=2 for JAL, 3 for JALR, 0 otherwise.
- The FSM SHALL then move to FETCH.
REQ-023 Handshake: once mem_req rises, mem_req and mem_we SHALL stay constant until the completing cycle; mem_ready outside FETCH/MEM SHALL be ignored.
REQ-024 Latency in cycles, FETCH entry to next FETCH entry with zero-wait memory:
- BRANCH 3.
- OP/OP-IMM/LUI/AUIPC/JAL/JALR 4.
- STORE 4.
- LOAD 5.
- Each memory wait cycle adds 1.
REQ-025 instret SHALL increment by 1 on each retire pulse and wrap from 0xFFFFFFFF to 0.
REQ-026 TRAP: all strobes 0, mem_req=0, ir and instret frozen; TRAP SHALL be exited only by reset.
REQ-027 rf_we, pc_en and retire SHALL never be high outside the cycles specified above.

Reset
REQ-028 On rst_n=0, all of the following SHALL take effect immediately, independent of clk: state=FETCH, ir=0, instret=0, illegal=0, bus_err=0, and all strobes and mem_req=0.
REQ-029 Reset asserted mid-access SHALL abandon the access; the first request after release SHALL be a fresh fetch.
REQ-030 On the first rising edge after rst_n release, the FSM SHALL be in FETCH with mem_req=1.

Configuration
REQ-031 Macro RV32I_SEQ_TIMEOUT_EN defined: an 8-bit wait counter SHALL run in the following way.
- It clears on entry to FETCH/MEM and counts cycles with mem_req=1 and mem_ready=0.
- When it reaches 255, the FSM SHALL set bus_err=1 and enter TRAP on that edge.
- mem_ready in the same cycle as count 255 SHALL win: the access completes normally.
REQ-032 Macro undefined: no counter, waits are unbounded, and bus_err SHALL be constant 0.

Verification
REQ-033 Zero-wait memory, fetch 0x00500093 (addi x1,x0,5) -> DECODE, EXEC, WB; rf_we=1 for 1 cycle; pc_en=1 with pc_sel=0; instret=1; 4 cycles.
REQ-034 Fetch 0x00002083 (lw), mem_ready low 3 cycles in MEM -> mem_req/mem_we=0 held stable; WB reached 1 cycle after ready; total 8 cycles.
REQ-035 Fetch 0x00000063 (beq) with branch_taken=1 -> pc_sel=1, no rf_we, back in FETCH after 3 cycles; with branch_taken=0 -> pc_sel=0.
REQ-036 Fetch 0xFFFFFFFF -> illegal=1, TRAP, mem_req=0 forever; mem_ready pulses ignored; rst_n low -> FETCH, illegal=0.
REQ-037 Fetch 0x00000033 (add x0) -> rf_we stays 0, pc_en=1.
- Preload instret=0xFFFFFFFF via 2^32-1 retires (or force) -> next retire gives 0.
REQ-038 With RV32I_SEQ_TIMEOUT_EN defined and mem_ready held 0 in FETCH -> bus_err=1 and TRAP after 256 request cycles.
- Without the macro -> FSM remains in FETCH indefinitely.
